// File: rtl/ofm_pkg.sv
// Shared definitions for the output-feature-map BRAM reader: FSM encoding and the
// slice/word-count arithmetic also used by the layer block and its bench.
package ofm_pkg;

  typedef enum logic [1:0] {StIdle, StRead, StDrain, StDone} state_e;

  function automatic int unsigned rows_of(input int unsigned p, input int unsigned pe_to_use,
                                          input int unsigned bram_size,
                                          input int unsigned last_bram_size);
    return (p == pe_to_use - 1) ? last_bram_size : bram_size;
  endfunction

  function automatic int unsigned word_count(input int unsigned out_fm_ch,
                                             input int unsigned pe_to_use,
                                             input int unsigned out_size,
                                             input int unsigned bram_size,
                                             input int unsigned last_bram_size);
    return out_fm_ch * out_size * ((pe_to_use - 1) * bram_size + last_bram_size);
  endfunction

endpackage

// File: rtl/stream_fifo2.sv
// Two-entry register FIFO; the head entry is always presented on o_data.
module stream_fifo2 #(
  parameter int unsigned W = 8
) (
  input  logic         i_clk,
  input  logic         i_rst_n,
  input  logic         i_push,
  input  logic         i_pop,
  input  logic [W-1:0] i_data,
  output logic [W-1:0] o_data,
  output logic [1:0]   o_count,
  output logic         o_full,
  output logic         o_empty
);

  logic [W-1:0] head_q, head_d, tail_q, tail_d;
  logic [1:0]   count_q, count_d;

  always_comb begin
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    case ({i_push, i_pop})
      2'b10: begin
        if (count_q == 2'd0) head_d = i_data;
        else                 tail_d = i_data;
        count_d = count_q + 2'd1;
      end
      2'b01: begin
        head_d  = tail_q;
        count_d = count_q - 2'd1;
      end
      2'b11: begin
        if (count_q == 2'd1) begin
          head_d = i_data;
        end else begin
          head_d = tail_q;
          tail_d = i_data;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= 2'd0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

  assign o_data  = head_q;
  assign o_count = count_q;
  assign o_full  = (count_q == 2'd2);
  assign o_empty = (count_q == 2'd0);

endmodule

// File: rtl/ofm_bram_reader.sv
// Walks every output BRAM slice (channel, PE, row, column) and re-emits the words as one
// raster-ordered valid/ready stream.
module ofm_bram_reader
  import ofm_pkg::*;
#(
  parameter int unsigned DW             = 16,
  parameter int unsigned PE_TO_USE      = 2,
  parameter int unsigned OUT_FM_CH      = 2,
  parameter int unsigned OUT_SIZE       = 4,
  parameter int unsigned BRAM_SIZE      = 2,
  parameter int unsigned LAST_BRAM_SIZE = 2,
  parameter int unsigned AW             = $clog2(OUT_SIZE**2) + 1
) (
  input  logic                              i_clk,
  input  logic                              i_rst_n,
  input  logic                              i_start,
  output logic [AW-1:0]                     o_bram_r_addr,
  output logic                              o_bram_r_en,
  input  logic [DW*PE_TO_USE*OUT_FM_CH-1:0] i_bram_r_data,
  output logic [DW-1:0]                     o_data,
  output logic                              o_valid,
  input  logic                              i_ready,
  output logic [$clog2(OUT_FM_CH):0]        o_ch,
  output logic                              o_last,
  output logic                              o_busy,
  output logic                              o_done
);

  localparam int unsigned CW   = $clog2(OUT_FM_CH) + 1;
  localparam int unsigned PW   = $clog2(PE_TO_USE) + 1;
  localparam int unsigned RMAX = (BRAM_SIZE > LAST_BRAM_SIZE) ? BRAM_SIZE : LAST_BRAM_SIZE;
  localparam int unsigned RW   = $clog2(RMAX) + 1;
  localparam int unsigned KW   = $clog2(OUT_SIZE) + 1;
  localparam int unsigned FW   = DW + CW + 1;

  state_e        state_q, state_d;
  logic [CW-1:0] c_q, c_d, tag_c_q, tag_c_d;
  logic [PW-1:0] p_q, p_d, tag_p_q, tag_p_d;
  logic [RW-1:0] r_q, r_d;
  logic [KW-1:0] k_q, k_d;
  logic [AW-1:0] addr_q, addr_d;
  logic          rd_en_q, rd_en_d, tag_last_q, tag_last_d;
  logic          busy_q, busy_d, done_q, done_d;

  logic          c_end, p_end, r_end, k_end;
  logic          push, pop, fifo_full, fifo_empty;
  logic [1:0]    fifo_count;
  logic [2:0]    occ;
  logic [DW-1:0] slice;
  logic [FW-1:0] fifo_dout;

  assign c_end = (c_q == CW'(OUT_FM_CH - 1));
  assign p_end = (p_q == PW'(PE_TO_USE - 1));
  assign k_end = (k_q == KW'(OUT_SIZE - 1));
  assign r_end = (32'(r_q) ==
                  rows_of(32'(p_q), PE_TO_USE, BRAM_SIZE, LAST_BRAM_SIZE) - 1);

  assign pop  = ~fifo_empty & i_ready;
  assign push = rd_en_q & (~fifo_full | pop);
  // Occupancy the FIFO will have after this edge, counting the read already in flight.
  assign occ  = {1'b0, fifo_count} + {2'b00, rd_en_q} - {2'b00, pop};

  always_comb begin
    slice = '0;
    for (int unsigned c = 0; c < OUT_FM_CH; c++) begin
      for (int unsigned p = 0; p < PE_TO_USE; p++) begin
        if (tag_c_q == CW'(c) && tag_p_q == PW'(p)) begin
          slice = i_bram_r_data[(c*PE_TO_USE+p)*DW +: DW];
        end
      end
    end
  end

  always_comb begin
    state_d    = state_q;
    c_d        = c_q;
    p_d        = p_q;
    r_d        = r_q;
    k_d        = k_q;
    addr_d     = addr_q;
    tag_c_d    = tag_c_q;
    tag_p_d    = tag_p_q;
    tag_last_d = tag_last_q;
    rd_en_d    = 1'b0;
    done_d     = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (i_start) begin
          state_d = StRead;
          c_d     = '0;
          p_d     = '0;
          r_d     = '0;
          k_d     = '0;
        end
      end
      StRead: begin
        if (occ < 3'd2) begin
          rd_en_d    = 1'b1;
          addr_d     = AW'(32'(r_q) * OUT_SIZE + 32'(k_q));
          tag_c_d    = c_q;
          tag_p_d    = p_q;
          tag_last_d = p_end & r_end & k_end;
          k_d        = k_q + 1'b1;
          if (k_end) begin
            k_d = '0;
            r_d = r_q + 1'b1;
            if (r_end) begin
              r_d = '0;
              p_d = p_q + 1'b1;
              if (p_end) begin
                p_d = '0;
                c_d = c_q + 1'b1;
                if (c_end) begin
                  c_d     = '0;
                  state_d = StDrain;
                end
              end
            end
          end
        end
      end
      StDrain: begin
        if (!rd_en_q && (fifo_count - {1'b0, pop}) == 2'd0) begin
          state_d = StDone;
          done_d  = 1'b1;
        end
      end
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // Busy lags the start edge by one cycle and drops together with the done pulse.
  assign busy_d = (state_q != StIdle) && (state_d == StRead || state_d == StDrain);

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q    <= StIdle;
      c_q        <= '0;
      p_q        <= '0;
      r_q        <= '0;
      k_q        <= '0;
      addr_q     <= '0;
      tag_c_q    <= '0;
      tag_p_q    <= '0;
      tag_last_q <= 1'b0;
      rd_en_q    <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      c_q        <= c_d;
      p_q        <= p_d;
      r_q        <= r_d;
      k_q        <= k_d;
      addr_q     <= addr_d;
      tag_c_q    <= tag_c_d;
      tag_p_q    <= tag_p_d;
      tag_last_q <= tag_last_d;
      rd_en_q    <= rd_en_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
    end
  end

  stream_fifo2 #(
    .W(FW)
  ) u_fifo (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .i_push  (push),
    .i_pop   (pop),
    .i_data  ({tag_last_q, tag_c_q, slice}),
    .o_data  (fifo_dout),
    .o_count (fifo_count),
    .o_full  (fifo_full),
    .o_empty (fifo_empty)
  );

  assign o_bram_r_addr = addr_q;
  assign o_bram_r_en   = rd_en_q;
  assign o_data        = fifo_dout[DW-1:0];
  assign o_ch          = fifo_dout[DW +: CW];
  assign o_last        = fifo_dout[FW-1];
  assign o_valid       = ~fifo_empty;
  assign o_busy        = busy_q;
  assign o_done        = done_q;

endmodule

// File: tb/tb_ofm_bram_reader.sv
// Bench for ofm_bram_reader: two instances (last PE with 2 rows and with 1 row), an
// index-arithmetic model of the raster stream and a per-cycle compare process.
module tb_ofm_bram_reader;
  import ofm_pkg::*;

  localparam int unsigned DW = 16;
  localparam int unsigned PE = 2;
  localparam int unsigned CH = 2;
  localparam int unsigned OS = 4;
  localparam int unsigned BS = 2;
  localparam int unsigned AW = $clog2(OS*OS) + 1;
  localparam int unsigned CW = $clog2(CH) + 1;
  localparam int unsigned BW = DW*PE*CH;
  localparam int unsigned EW = DW + CW + 1;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic          start [2];
  logic          ready [2];
  logic [AW-1:0] addr  [2];
  logic          en    [2];
  logic [BW-1:0] rdata [2];
  logic [DW-1:0] data  [2];
  logic          valid [2];
  logic [CW-1:0] ch    [2];
  logic          last  [2];
  logic          busy  [2];
  logic          done  [2];

  ofm_bram_reader #(
    .DW(DW), .PE_TO_USE(PE), .OUT_FM_CH(CH), .OUT_SIZE(OS), .BRAM_SIZE(BS),
    .LAST_BRAM_SIZE(2), .AW(AW)
  ) dut0 (
    .i_clk(clk), .i_rst_n(rst_n), .i_start(start[0]), .o_bram_r_addr(addr[0]),
    .o_bram_r_en(en[0]), .i_bram_r_data(rdata[0]), .o_data(data[0]), .o_valid(valid[0]),
    .i_ready(ready[0]), .o_ch(ch[0]), .o_last(last[0]), .o_busy(busy[0]), .o_done(done[0])
  );

  ofm_bram_reader #(
    .DW(DW), .PE_TO_USE(PE), .OUT_FM_CH(CH), .OUT_SIZE(OS), .BRAM_SIZE(BS),
    .LAST_BRAM_SIZE(1), .AW(AW)
  ) dut1 (
    .i_clk(clk), .i_rst_n(rst_n), .i_start(start[1]), .o_bram_r_addr(addr[1]),
    .o_bram_r_en(en[1]), .i_bram_r_data(rdata[1]), .o_data(data[1]), .o_valid(valid[1]),
    .i_ready(ready[1]), .o_ch(ch[1]), .o_last(last[1]), .o_busy(busy[1]), .o_done(done[1])
  );

  function automatic int unsigned lrows(input int k);
    return (k == 0) ? 2 : 1;
  endfunction

  function automatic int unsigned total(input int k);
    return word_count(CH, PE, OS, BS, lrows(k));
  endfunction

  // Raster word i: channel-major, then PE slice, then address inside the slice.
  function automatic logic [EW-1:0] exp_word(input int unsigned i, input int unsigned lr);
    int unsigned per_ch, c, w, p, off;
    per_ch = OS * ((PE-1)*BS + lr);
    c      = i / per_ch;
    w      = i % per_ch;
    p      = (w < (PE-1)*BS*OS) ? w / (BS*OS) : PE-1;
    off    = w - p*BS*OS;
    return {(w == per_ch-1), CW'(c), DW'((c << 8) | (p << 4) | off)};
  endfunction

  // Zero-latency view of a registered-address BRAM; junk whenever enable is low.
  function automatic logic [BW-1:0] bram(input logic e, input logic [AW-1:0] a,
                                         input logic [DW-1:0] j);
    logic [BW-1:0] v;
    v = '0;
    for (int unsigned c = 0; c < CH; c++)
      for (int unsigned p = 0; p < PE; p++)
        v[(c*PE+p)*DW +: DW] = e ? DW'((c << 8) | (p << 4) | 32'(a)) : j ^ DW'(c*PE+p);
    return v;
  endfunction

  logic [DW-1:0] junk = '0;
  always @(posedge clk) junk <= DW'($urandom);
  assign rdata[0] = bram(en[0], addr[0], junk);
  assign rdata[1] = bram(en[1], addr[1], junk);

  int unsigned   checks = 0;
  int unsigned   errors = 0;
  int unsigned   cyc = 0;
  int unsigned   idx [2] = '{0, 0};
  int unsigned   ndone [2] = '{0, 0};
  int unsigned   last_hs [2] = '{0, 0};
  logic          hold [2] = '{1'b0, 1'b0};
  logic [EW-1:0] held [2];
  logic [EW-1:0] got [2][64];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s got %0h expected %0h (t=%0t)", name, act, req, $time);
    end
  endtask

  always @(negedge clk) begin
    cyc++;
    for (int k = 0; k < 2; k++) begin
      if (!rst_n) begin
        idx[k]  = 0;
        hold[k] = 1'b0;
      end else begin
        if (start[k] && !busy[k] && !valid[k]) idx[k] = 0;
        if (hold[k]) begin
          check("hold_valid", valid[k], 1);
          check("hold_word", {last[k], ch[k], data[k]}, held[k]);
        end
        if (valid[k] && ready[k]) begin
          check("word_in_range", idx[k] < total(k), 1);
          if (idx[k] < total(k))
            check("stream_word", {last[k], ch[k], data[k]}, exp_word(idx[k], lrows(k)));
          if (idx[k] < 64) got[k][idx[k]] = {last[k], ch[k], data[k]};
          idx[k]++;
          last_hs[k] = cyc;
        end
        hold[k] = valid[k] && !ready[k];
        held[k] = {last[k], ch[k], data[k]};
        if (done[k]) begin
          check("done_timing", cyc, last_hs[k] + 1);
          check("done_words", idx[k], total(k));
          ndone[k]++;
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_zero(input int k);
    check("rst_addr", addr[k], 0);
    check("rst_en", en[k], 0);
    check("rst_data", data[k], 0);
    check("rst_valid", valid[k], 0);
    check("rst_ch", ch[k], 0);
    check("rst_last", last[k], 0);
    check("rst_busy", busy[k], 0);
    check("rst_done", done[k], 0);
  endtask

  // mode 0: ready high, 1: random 30% low, 2: low for 20 cycles, 3: start re-pulsed at word 5
  task automatic run(input int k, input int mode);
    int unsigned base, reads;
    logic        repulsed;
    base     = ndone[k];
    repulsed = 1'b0;
    start[k] = 1'b1;
    tick();
    start[k] = 1'b0;
    check("busy_lag", busy[k], 0);
    check("en_lag", en[k], 0);
    tick();
    check("busy_rise", busy[k], 1);
    check("en_rise", en[k], 1);
    check("addr_first", addr[k], 0);
    check("valid_lag", valid[k], 0);
    reads = 1;
    tick();
    check("valid_rise", valid[k], 1);
    for (int i = 0; i < 600 && ndone[k] == base; i++) begin
      if (mode == 1) ready[k] = ($urandom_range(0, 99) >= 30);
      if (mode == 2) begin
        ready[k] = (i >= 20);
        if (i < 20) reads += 32'(en[k]);
        if (i == 20) begin
          check("stall_reads_le2", reads <= 2, 1);
          check("stall_en_low", en[k], 0);
        end
      end
      if (mode == 3) begin
        start[k] = (idx[k] == 5) && !repulsed;
        if (start[k]) repulsed = 1'b1;
      end
      tick();
    end
    start[k] = 1'b0;
    ready[k] = 1'b1;
    if (mode == 3) check("repulse_sent", repulsed, 1);
    check("done_seen", ndone[k], base + 1);
    repeat (4) tick();
    check("single_done", ndone[k], base + 1);
    check("idle_after", busy[k], 0);
    check("word_total", idx[k], total(k));
  endtask

  initial begin
    for (int k = 0; k < 2; k++) begin
      start[k] = 1'b0;
      ready[k] = 1'b1;
    end
    rst_n = 1'b0;
    repeat (3) tick();
    check_zero(0);
    check_zero(1);
    rst_n = 1'b1;
    repeat (2) tick();

    check("count_fn_full", total(0), 32);
    check("count_fn_short", total(1), 24);

    run(0, 0);
    check("w0_data", got[0][0][DW-1:0], 16'h0000);
    check("w8_data", got[0][8][DW-1:0], 16'h0010);
    check("w14_last", got[0][14][EW-1], 0);
    check("w15_data", got[0][15][DW-1:0], 16'h0017);
    check("w15_last", got[0][15][EW-1], 1);
    check("w16_data", got[0][16][DW-1:0], 16'h0100);
    check("w16_ch", got[0][16][DW +: CW], 1);
    check("w31_data", got[0][31][DW-1:0], 16'h0117);
    check("w31_last", got[0][31][EW-1], 1);

    run(0, 1);
    run(0, 3);
    run(0, 2);

    start[0] = 1'b1;
    tick();
    start[0] = 1'b0;
    for (int i = 0; i < 100 && idx[0] < 10; i++) tick();
    check("reached_w10", idx[0], 10);
    rst_n = 1'b0;
    #1;
    check_zero(0);
    repeat (2) tick();
    rst_n = 1'b1;
    repeat (3) tick();
    check("post_rst_idle", busy[0], 0);
    check("post_rst_novalid", valid[0], 0);
    run(0, 0);
    check("rerun_w0", got[0][0], {1'b0, CW'(0), 16'h0000});

    run(1, 0);
    check("s_w11_data", got[1][11][DW-1:0], 16'h0013);
    check("s_w11_last", got[1][11][EW-1], 1);
    check("s_w12_data", got[1][12][DW-1:0], 16'h0100);
    check("s_w23_data", got[1][23][DW-1:0], 16'h0113);
    check("s_w23_last", got[1][23][EW-1], 1);
    run(1, 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
